// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: samples a divided clock as data, detects its rising edges and steps a BCD counter.
// Define TICK_BCD_SATURATE_EN to saturate at all-9s / zero instead of wrapping.
module tick_bcd_counter #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic                  clock_in,
    input  logic                  rst_n,
    input  logic                  tick_in,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick_seen,
    output logic                  carry
);
    localparam int W = 4 * DIGITS;

`ifdef TICK_BCD_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   step;

    logic [W-1:0]           count_q, count_d;
    logic                   tick_seen_q, tick_seen_d;
    logic                   carry_q, carry_d;

    logic [W-1:0]           count_inc, count_dec, load_clamped;
    logic [DIGITS-1:0]      is9, is0;
    logic [DIGITS:0]        inc_chain, dec_chain;
    logic                   wrap_up, wrap_dn;

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign step = sync_q[SYNC_STAGES-1] & ~hist_q;

    // inc_chain[i] / dec_chain[i]: every digit below i is 9 / 0, so digit i must roll.
    always_comb begin
        inc_chain    = '0;
        dec_chain    = '0;
        inc_chain[0] = 1'b1;
        dec_chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            inc_chain[i+1] = inc_chain[i] & is9[i];
            dec_chain[i+1] = dec_chain[i] & is0[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] dig;
            logic [3:0] ld;
            assign dig = count_q[4*gi +: 4];
            assign ld  = load_val[4*gi +: 4];
            assign is9[gi] = (dig == 4'd9);
            assign is0[gi] = (dig == 4'd0);
            assign count_inc[4*gi +: 4] = !inc_chain[gi] ? dig :
                                          (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            assign count_dec[4*gi +: 4] = !dec_chain[gi] ? dig :
                                          (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            assign load_clamped[4*gi +: 4] = (ld > 4'd9) ? 4'd9 : ld;
        end
    endgenerate

    assign wrap_up = inc_chain[DIGITS];
    assign wrap_dn = dec_chain[DIGITS];

    always_comb begin
        count_d     = count_q;
        tick_seen_d = 1'b0;
        carry_d     = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (step && en) begin
            tick_seen_d = 1'b1;
            if (up) begin
                carry_d = wrap_up;
                if (!(SATURATE && wrap_up)) count_d = count_inc;
            end else begin
                carry_d = wrap_dn;
                if (!(SATURATE && wrap_dn)) count_d = count_dec;
            end
        end
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            tick_seen_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            tick_seen_q <= tick_seen_d;
            carry_q     <= carry_d;
        end
    end

    assign count     = count_q;
    assign tick_seen = tick_seen_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Testbench for tick_bcd_counter: directed scenarios plus randomized traffic against an integer reference model.
module tb_tick_bcd_counter;
    localparam int DIGITS = 4;
    localparam int SYNC   = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;
`ifdef TICK_BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clock_in = 1'b0;
    logic         rst_n    = 1'b0;
    logic         tick_in  = 1'b0;
    logic         en       = 1'b1;
    logic         up       = 1'b1;
    logic         clear    = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tick_seen;
    logic         carry;

    int n_cmp = 0;
    int n_err = 0;

    tick_bcd_counter #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC)) dut (
        .clock_in (clock_in),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .en       (en),
        .up       (up),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick_seen(tick_seen),
        .carry    (carry)
    );

    always #5 clock_in = ~clock_in;

    // Reference model: counter kept as a plain integer 0..MAXV, tick_in samples kept as a history.
    typedef struct packed { int val; logic tk; logic cy; } mres_t;
    mres_t m_res = '0;
    bit    samp[$];

    function automatic logic [W-1:0] int_to_bcd(int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_to_int(logic [W-1:0] b);
        int v = 0;
        int scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    // A rising edge sampled at edge k takes effect at edge k+SYNC.
    function automatic bit step_now();
        int n = samp.size();
        if (n < SYNC) return 1'b0;
        if (!samp[n-SYNC]) return 1'b0;
        if (n > SYNC && samp[n-SYNC-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic mres_t model_next(mres_t cur, bit st);
        mres_t r;
        r.val = cur.val;
        r.tk  = 1'b0;
        r.cy  = 1'b0;
        if (clear) r.val = 0;
        else if (load) r.val = load_to_int(load_val);
        else if (st && en) begin
            r.tk = 1'b1;
            if (up) begin
                if (cur.val == MAXV) begin r.cy = 1'b1; r.val = SAT ? MAXV : 0; end
                else r.val = cur.val + 1;
            end else begin
                if (cur.val == 0) begin r.cy = 1'b1; r.val = SAT ? 0 : MAXV; end
                else r.val = cur.val - 1;
            end
        end
        return r;
    endfunction

    always @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            samp.delete();
            m_res <= '0;
        end else begin
            m_res <= model_next(m_res, step_now());
            samp.push_back(tick_in);
        end
    end

    // Stimulus helpers: all drives happen just after a falling edge.
    task automatic tick_pulse();
        @(negedge clock_in); tick_in = 1'b1;
        @(negedge clock_in); tick_in = 1'b0;
    endtask

    task automatic do_load(logic [W-1:0] v);
        @(negedge clock_in); load = 1'b1; load_val = v;
        @(negedge clock_in); load = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clock_in); clear = 1'b1;
        @(negedge clock_in); clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock_in);
        #1;
        n_cmp++; if (count !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h expected 0000", count); end
        n_cmp++; if (tick_seen !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick_seen); end
        n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", carry); end
        @(negedge clock_in); rst_n = 1'b1;
        repeat (5) @(negedge clock_in);
        tick_in = 1'b1;
        @(posedge clock_in);                       // edge N
        @(negedge clock_in); tick_in = 1'b0;
        @(posedge clock_in); #1;                   // edge N+1
        n_cmp++; if (tick_seen !== 1'b0) begin n_err++; $display("FAIL first_early: got tick %b expected 0", tick_seen); end
        @(posedge clock_in); #1;                   // edge N+2
        n_cmp++; if (count !== 16'h0001) begin n_err++; $display("FAIL first_count: got %h expected 0001", count); end
        n_cmp++; if (tick_seen !== 1'b1) begin n_err++; $display("FAIL first_tick: got %b expected 1", tick_seen); end
        @(posedge clock_in); #1;                   // edge N+3
        n_cmp++; if (tick_seen !== 1'b0) begin n_err++; $display("FAIL first_tick_drop: got %b expected 0", tick_seen); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_v;
        do_load(16'h9999);
        up = 1'b1;
        tick_pulse();
        @(posedge clock_in); @(posedge clock_in); #1;
        exp_v = SAT ? 16'h9999 : 16'h0000;
        n_cmp++; if (count !== exp_v) begin n_err++; $display("FAIL wrap_up_count: got %h expected %h", count, exp_v); end
        n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL wrap_up_carry: got %b expected 1", carry); end
        @(posedge clock_in); #1;
        n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL wrap_up_carry_drop: got %b expected 0", carry); end
        do_clear();
        up = 1'b0;
        tick_pulse();
        @(posedge clock_in); @(posedge clock_in); #1;
        exp_v = SAT ? 16'h0000 : 16'h9999;
        n_cmp++; if (count !== exp_v) begin n_err++; $display("FAIL wrap_dn_count: got %h expected %h", count, exp_v); end
        n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL wrap_dn_carry: got %b expected 1", carry); end
        n_cmp++; if (tick_seen !== 1'b1) begin n_err++; $display("FAIL wrap_dn_tick: got %b expected 1", tick_seen); end
        up = 1'b1;
    endtask

    task automatic test_chain();
        do_load(16'h0199);
        up = 1'b1;
        tick_pulse();
        @(posedge clock_in); @(posedge clock_in); #1;
        n_cmp++; if (count !== 16'h0200) begin n_err++; $display("FAIL chain_up: got %h expected 0200", count); end
        n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL chain_up_carry: got %b expected 0", carry); end
        @(negedge clock_in); up = 1'b0;
        tick_pulse();
        @(posedge clock_in); @(posedge clock_in); #1;
        n_cmp++; if (count !== 16'h0199) begin n_err++; $display("FAIL chain_dn: got %h expected 0199", count); end
        n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL chain_dn_carry: got %b expected 0", carry); end
        up = 1'b1;
    endtask

    task automatic test_priority();
        do_clear();
        tick_pulse();                              // now half a cycle after edge N
        @(negedge clock_in); load = 1'b1; load_val = 16'h3A7F;
        @(posedge clock_in); #1;                   // edge N+2: step coincides with load
        n_cmp++; if (count !== 16'h3979) begin n_err++; $display("FAIL prio_count: got %h expected 3979", count); end
        n_cmp++; if (tick_seen !== 1'b0) begin n_err++; $display("FAIL prio_tick: got %b expected 0", tick_seen); end
        @(negedge clock_in); load = 1'b0;
        repeat (4) @(posedge clock_in);
        #1;
        n_cmp++; if (count !== 16'h3979) begin n_err++; $display("FAIL prio_lost: got %h expected 3979", count); end
    endtask

    task automatic test_enable();
        @(negedge clock_in); en = 1'b0;
        tick_pulse();
        @(posedge clock_in); @(posedge clock_in); #1;
        n_cmp++; if (tick_seen !== 1'b0) begin n_err++; $display("FAIL en_tick: got %b expected 0", tick_seen); end
        n_cmp++; if (count !== 16'h3979) begin n_err++; $display("FAIL en_count: got %h expected 3979", count); end
        @(negedge clock_in); en = 1'b1;
        repeat (4) @(posedge clock_in);
        #1;
        n_cmp++; if (count !== 16'h3979) begin n_err++; $display("FAIL en_not_queued: got %h expected 3979", count); end
    endtask

    task automatic test_long_high();
        int pulses = 0;
        do_clear();
        up = 1'b1;
        for (int c = 0; c < 126; c++) begin
            @(negedge clock_in);
            tick_in = (c < 120) && ((c % 40) < 20);
            @(posedge clock_in); #1;
            if (tick_seen === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL long_pulses: got %0d expected 3", pulses); end
        n_cmp++; if (count !== 16'h0003) begin n_err++; $display("FAIL long_count: got %h expected 0003", count); end
    endtask

    task automatic test_reset_midflight();
        int spurious = 0;
        do_load(16'h0042);
        @(negedge clock_in); tick_in = 1'b1;
        @(negedge clock_in); rst_n = 1'b0; tick_in = 1'b0;
        #1;
        n_cmp++; if (count !== 16'h0000) begin n_err++; $display("FAIL mid_reset_count: got %h expected 0000", count); end
        @(negedge clock_in); rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock_in); #1;
            if (tick_seen !== 1'b0) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL mid_no_step: got %0d ticks expected 0", spurious); end
        n_cmp++; if (count !== 16'h0000) begin n_err++; $display("FAIL mid_count_after: got %h expected 0000", count); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_c;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock_in);
            tick_in = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 3) != 0);
            up      = 1'($urandom_range(0, 1));
            clear   = ($urandom_range(0, 29) == 0);
            load    = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                2:       load_val = 16'h9998;
                default: load_val = 16'($urandom);
            endcase
            @(posedge clock_in); #1;
            exp_c = int_to_bcd(m_res.val);
            n_cmp++; if (count !== exp_c) begin n_err++; $display("FAIL rand_count c=%0d: got %h expected %h", c, count, exp_c); end
            n_cmp++; if (tick_seen !== m_res.tk) begin n_err++; $display("FAIL rand_tick c=%0d: got %b expected %b", c, tick_seen, m_res.tk); end
            n_cmp++; if (carry !== m_res.cy) begin n_err++; $display("FAIL rand_carry c=%0d: got %b expected %b", c, carry, m_res.cy); end
        end
        @(negedge clock_in);
        tick_in = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_chain();
        test_priority();
        test_enable();
        test_long_high();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the Clock_Divider output. Samples the divided clock as a data signal in the fast clock_in domain, detects its rising edges and advances a multi-digit BCD counter by one per edge.
- Result drives the lab display path.
- The divided clock is never used as a clock; the whole block runs on clock_in.

Parameters:
- DIGITS, 4: number of BCD digits; count width is 4*DIGITS.
- SYNC_STAGES, 2: synchroniser flops on tick_in; legal range 2..4.

Ports:
- clock_in  input  1  system clock, same clock that feeds Clock_Divider.
- rst_n  input  1  reset, asynchronous, active-low.
- tick_in  input  1  Clock_Divider clock_out, treated as asynchronous data.
- en  input  1  step enable.
- up  input  1  1 = count up, 0 = count down.
- clear  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- count  output  4*DIGITS  current BCD count.
- tick_seen  output  1  one-cycle pulse when a step is applied.
- carry  output  1  one-cycle pulse on wrap (up 99..9->0, down 0->99..9).

Behaviour:
- Clocking and reset:
  - One clock, clock_in. Reset is asynchronous and active-low on rst_n.
  - On reset: count=0, tick_seen=0, carry=0, all synchroniser flops and the edge-history flop = 0.
- Synchronisation and edge detect:
  - tick_in passes through a SYNC_STAGES-deep flop chain.
  - step = last_sync & ~hist, where hist is last_sync delayed one cycle.
  - tick_in high at reset release counts as one rising edge.
- Latency:
  - Let edge N be the first clock_in edge that samples tick_in high.
  - The resulting step updates count, tick_seen and carry at edge N+SYNC_STAGES.
  - One step per tick_in rising edge regardless of tick_in high time (at least 1 clock_in cycle).
- Priority, evaluated per clock edge:
  - clear > load > (step & en).
  - clear: count=0, no tick_seen, no carry.
  - load: each digit = load_val digit; any digit >9 is loaded as 9. No tick_seen, no carry.
  - step & en: tick_seen=1; count +1 or -1 in BCD per up.
  - step & ~en: step is discarded, not queued; tick_seen=0.
  - A step coincident with clear or load is discarded.
- BCD arithmetic:
  - Up: a digit at 9 goes to 0 and increments the next digit.
  - Down: a digit at 0 goes to 9 and decrements the next digit.
  - Wrap (up from all-9s to 0, down from 0 to all-9s) asserts carry for exactly the cycle in which count takes the wrapped value.
- Outputs:
  - tick_seen and carry are registered and high for one cycle only.
  - count is registered and holds between steps.
- Changing up or en between steps takes effect on the next step only.
- Reset mid-operation: immediate asynchronous return to reset values. Any in-flight edge in the synchroniser is lost.

Optional Feature:
- Macro TICK_BCD_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping: up at all-9s holds all-9s; down at 0 holds 0.
  - carry pulses on the saturated attempt; tick_seen still pulses.
- Undefined: wrap behaviour as in Behaviour.

Test Plan:
- Reset and first step (DIGITS=4, SYNC_STAGES=2, en=1, up=1):
  - Stimulus: hold rst_n=0 for 3 cycles, release; tick_in low 5 cycles, then high for 1 cycle at edge N.
  - Response: count=0000 through reset. count=0001 and tick_seen=1 at edge N+2. tick_seen=0 at edge N+3.
- Wrap up and down:
  - Stimulus: load 9999 then apply one up step. Separately, clear then apply one down step.
  - Response, wrap build: count=0000 with carry=1 for one cycle.
  - Response, saturate build: count holds 9999 with carry=1.
  - Response, down step: count=9999 with carry=1 (wrap build) or count holds 0000 with carry=1 (saturate build).
- Digit carry chain:
  - Stimulus: load 0199, apply one up step, then one down step.
  - Response: count=0200 then 0199; carry=0 throughout.
- Priority and enable:
  - Stimulus: time a step to coincide with load=1 and load_val=0x3A7F.
  - Response: count=3979, no tick_seen, step lost.
  - Stimulus: apply a step with en=0.
  - Response: count unchanged, tick_seen=0.
- Long tick_in high:
  - Stimulus: tick_in high for 20 cycles, low for 20 cycles, repeated 3 times from 0000.
  - Response: count=0003, exactly 3 tick_seen pulses.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 one cycle after tick_in rises.
  - Response: count=0000 immediately. No step after release while tick_in stays low.
